// File: rtl/binconv_engine.sv
// Binary XNOR/popcount 2-D convolution engine with run-time kernel size K (1..KMAX).
// Loads K, weights, image dimensions and rows from SRAMs, writes one thresholded row per word.
module binconv_engine #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int KMAX     = 5,
  parameter int OUT_BASE = 0
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_valid,
  output logic              dut_busy,
  output logic              dut_error,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable
);

  localparam int KW  = $clog2(KMAX + 1);
  localparam int CTW = KW + 1;
  localparam int IW  = (KMAX > 1) ? $clog2(KMAX) : 1;
  localparam int MW  = $clog2(KMAX * KMAX + 1);
  localparam int SW  = MW + 1;
  localparam int JW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [3:0] {IDLE, LD_K, LD_W, LD_DIM, FILL, CONV, WRITE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CTW-1:0]    cnt_q, cnt_d, rd_idx_q, rd_idx_d;
  logic              rd_v_q, rd_v_d, busy_q, busy_d, err_q, err_d;
  logic [DATA_W-1:0] k_q, k_d, nr_q, nr_d, nc_q, nc_d, i_q, i_d, tmp_q, tmp_d;
  logic [JW-1:0]     j_q, j_d;
  logic [KMAX-1:0]   w_q [KMAX];
  logic [KMAX-1:0]   w_d [KMAX];
  logic [DATA_W-1:0] buf_q [KMAX];
  logic [DATA_W-1:0] buf_d [KMAX];

  logic [KW-1:0]     kk;
  logic [CTW-1:0]    nrows;
  logic [KMAX-1:0]   kmask;
  logic              bad;

  assign kk    = k_q[KW-1:0];
  // Weight rows are only fetched when K fits; oversize K is caught by the error check.
  assign nrows = (k_q <= DATA_W'(KMAX)) ? CTW'(kk) : '0;
  assign bad   = (k_q == '0) || (k_q > DATA_W'(KMAX)) || (nc_q == '0) ||
                 (nc_q > DATA_W'(DATA_W)) || (k_q > nr_q) || (k_q > nc_q);

  always_comb begin
    kmask = '0;
    for (int c = 0; c < KMAX; c++) kmask[c] = (c < int'(kk));
  end

  // Window rows are the K newest buffer entries; buffer slot b maps to kernel row b-(KMAX-K).
  logic [SW-1:0]     m;
  logic [DATA_W-1:0] rs;
  logic [IW-1:0]     wr;
  logic              win_bit;

  always_comb begin
    m  = '0;
    rs = '0;
    wr = '0;
    for (int b = 0; b < KMAX; b++) begin
      rs = buf_q[b] >> j_q;
      wr = IW'(b + int'(kk) - KMAX);
      if (b + int'(kk) >= KMAX) begin
        for (int c = 0; c < KMAX; c++) begin
          if (c < int'(kk) && rs[c] == w_q[wr][c]) m = m + SW'(1);
        end
      end
    end
    win_bit = (m << 1) >= (SW'(kk) * SW'(kk));
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_idx_q <= '0;
      rd_v_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      k_q      <= '0;
      nr_q     <= '0;
      nc_q     <= '0;
      i_q      <= '0;
      j_q      <= '0;
      tmp_q    <= '0;
      for (int r = 0; r < KMAX; r++) begin
        w_q[r]   <= '0;
        buf_q[r] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_idx_q <= rd_idx_d;
      rd_v_q   <= rd_v_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      k_q      <= k_d;
      nr_q     <= nr_d;
      nc_q     <= nc_d;
      i_q      <= i_d;
      j_q      <= j_d;
      tmp_q    <= tmp_d;
      for (int r = 0; r < KMAX; r++) begin
        w_q[r]   <= w_d[r];
        buf_q[r] <= buf_d[r];
      end
    end
  end

  // Reads are pipelined: a word issued in one cycle is captured the next (rd_v_q/rd_idx_q).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_idx_d = rd_idx_q;
    rd_v_d   = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
    k_d      = k_q;
    nr_d     = nr_q;
    nc_d     = nc_q;
    i_d      = i_q;
    j_d      = j_q;
    tmp_d    = tmp_q;
    w_d      = w_q;
    buf_d    = buf_q;
    case (state_q)
      IDLE: if (dut_valid) begin
        state_d = LD_K;
        cnt_d   = '0;
        busy_d  = 1'b1;
        err_d   = 1'b0;
      end
      LD_K: if (cnt_q == '0) begin
        cnt_d = CTW'(1);
      end else begin
        k_d = wmem_dut_read_data;
        for (int r = 0; r < KMAX; r++) w_d[r] = '0;
        cnt_d   = '0;
        state_d = LD_W;
      end
      LD_W: begin
        if (cnt_q < nrows) begin
          rd_v_d   = 1'b1;
          rd_idx_d = cnt_q;
          cnt_d    = cnt_q + CTW'(1);
        end
        if (rd_v_q) begin
          w_d[rd_idx_q[IW-1:0]] = wmem_dut_read_data[KMAX-1:0] & kmask;
        end else if (cnt_q >= nrows) begin
          state_d = LD_DIM;
          cnt_d   = '0;
        end
      end
      LD_DIM: begin
        if (cnt_q < CTW'(2)) begin
          rd_v_d   = 1'b1;
          rd_idx_d = cnt_q;
          cnt_d    = cnt_q + CTW'(1);
        end
        if (rd_v_q) begin
          if (rd_idx_q == '0) nr_d = sram_dut_read_data;
          else                nc_d = sram_dut_read_data;
        end else if (cnt_q == CTW'(2)) begin
          cnt_d = '0;
          if (bad) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (cnt_q < CTW'(kk)) begin
          rd_v_d = 1'b1;
          cnt_d  = cnt_q + CTW'(1);
        end
        if (rd_v_q) begin
          for (int b = 0; b < KMAX - 1; b++) buf_d[b] = buf_q[b + 1];
          buf_d[KMAX-1] = sram_dut_read_data;
        end else if (cnt_q >= CTW'(kk)) begin
          state_d = CONV;
          i_d     = '0;
          j_d     = '0;
          tmp_d   = '0;
        end
      end
      CONV: begin
        tmp_d[j_q] = win_bit;
        if (DATA_W'(j_q) == nc_q - k_q) state_d = WRITE;
        else                            j_d = j_q + JW'(1);
      end
      WRITE: begin
        tmp_d = '0;
        j_d   = '0;
        cnt_d = '0;
        if (i_q == nr_q - k_q) state_d = DONE;
        else                   state_d = SHIFT;
      end
      SHIFT: if (cnt_q == '0) begin
        cnt_d = CTW'(1);
      end else begin
        for (int b = 0; b < KMAX - 1; b++) buf_d[b] = buf_q[b + 1];
        buf_d[KMAX-1] = sram_dut_read_data;
        i_d     = i_q + DATA_W'(1);
        cnt_d   = '0;
        state_d = CONV;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dut_sram_read_address = '0;
    dut_wmem_read_address = '0;
    case (state_q)
      LD_W:   if (cnt_q < nrows) dut_wmem_read_address = ADDR_W'(cnt_q) + ADDR_W'(1);
      LD_DIM: if (cnt_q < CTW'(2)) dut_sram_read_address = ADDR_W'(cnt_q);
      FILL:   if (cnt_q < CTW'(kk)) dut_sram_read_address = ADDR_W'(cnt_q) + ADDR_W'(2);
      SHIFT:  if (cnt_q == '0) dut_sram_read_address = ADDR_W'(i_q + k_q + DATA_W'(2));
      default: ;
    endcase
  end

  assign dut_sram_write_enable  = (state_q == WRITE);
  assign dut_sram_write_address = dut_sram_write_enable ? ADDR_W'(OUT_BASE) + ADDR_W'(i_q) : '0;
  assign dut_sram_write_data    = dut_sram_write_enable ? tmp_q : '0;
  assign dut_busy               = busy_q;
  assign dut_error              = err_q;

endmodule

// File: doc/binconv_engine.md
Name: binconv_engine

Overview:
- Parametrised binary (XNOR/popcount) 2-D convolution engine with integrated controller. Replaces the fixed 3x3, 16-column datapath/controller pair.
- Reads the weight kernel from weight memory and the input bitmap from input SRAM, one row per word.
- Slides a KxK window, with K chosen at run time (1..KMAX), over the image.
- Writes one packed thresholded output row per SRAM word.

Parameters:
- DATA_W, 16, bits per SRAM word; also the maximum image columns.
- ADDR_W, 12, SRAM and weight-memory address width.
- KMAX, 5, largest supported kernel dimension (KMAX <= DATA_W).
- OUT_BASE, 0, first output SRAM write address of each job.

Ports:
- clk  in  1  clock
- reset_b  in  1  asynchronous active-low reset
- dut_valid  in  1  start pulse; sampled only in IDLE
- dut_busy  out  1  high from the cycle after an accepted start until return to IDLE
- dut_error  out  1  sticky error for the last job; cleared on the next accepted start
- dut_sram_read_address  out  ADDR_W  input SRAM read address
- sram_dut_read_data  in  DATA_W  input SRAM data, valid 1 cycle after its address
- dut_wmem_read_address  out  ADDR_W  weight memory read address
- wmem_dut_read_data  in  DATA_W  weight data, valid 1 cycle after its address
- dut_sram_write_address  out  ADDR_W  output write address
- dut_sram_write_data  out  DATA_W  output write data
- dut_sram_write_enable  out  1  single-cycle write strobe, qualified with address and data in the same cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on reset_b.
- Reset values: every output is 0; FSM is IDLE; line buffer, weight registers and counters are cleared.
- Reset mid-job: aborts immediately. No further writes are issued; the next job needs a fresh dut_valid.
- Memory map, weights:
  - wmem[0] = K.
  - wmem[1+r] = kernel row r, r = 0..K-1, using bits [K-1:0].
- Memory map, input:
  - sram[0] = NR (rows), sram[1] = NC (columns).
  - sram[2+r] = image row r; bit c is column c, with column 0 at the LSB.
- Geometry: output is OR = NR-K+1 rows by OC = NC-K+1 columns. Output row i is written at OUT_BASE+i.
- Output bit j of row i is 1 iff 2*M >= K*K, where:
  - M = number of positions (r,c), r,c in 0..K-1, with input[i+r][j+c] == weight[r][c].
  - M uses width ceil(log2(KMAX*KMAX+1)).
  - Output bits OC..DATA_W-1 are 0.
- FSM states: IDLE, LD_K, LD_W, LD_DIM, FILL, CONV, WRITE, SHIFT, DONE.
- IDLE: on dut_valid go to LD_K and clear dut_error. dut_valid in any other state is ignored.
- LD_K: read wmem[0] and latch K. Go to LD_W.
- LD_W: read K rows into the weight registers. Rows >= K are zeroed.
- LD_DIM: read NR and NC.
- Error check, done before FILL:
  - Condition: K==0, K>KMAX, NC==0, NC>DATA_W, K>NR or K>NC.
  - Action: set dut_error, go to DONE, issue zero writes.
- FILL: read image rows 0..K-1 into a KMAX-deep row shift buffer. The newest row enters at the bottom; the K most recent rows form the window.
- CONV: one output column per cycle, j = 0..OC-1. The window compare/popcount/threshold is computed combinationally and the result bit is registered into the output temp word. Takes OC cycles.
- WRITE (1 cycle): pulse write enable with the temp word at address OUT_BASE+i, then clear the temp word.
  - If i == OR-1, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT: read image row i+K (1 cycle of read latency) and shift it into the buffer. Increment i and go to CONV.
  - The SHIFT row read may be issued during the last CONV cycle to hide latency. The observed write sequence must be identical either way.
- DONE (1 cycle): return to IDLE. dut_busy falls on entering IDLE.
- Write ordering: exactly OR writes per good job, strictly increasing addresses, never two strobes in consecutive cycles.
- Read addresses never exceed 1+NR on the input SRAM or K on the weight memory.
- Boundary cases:
  - K==1: output equals XNOR of each input bit with weight bit 0.
  - NC==K: one-bit output rows.
  - NR==K: exactly one write.

Test Plan:
- K=3, NR=NC=16, all input rows 0xFFFF, weights 0x7 x3 -> 14 writes at addresses 0..13, each data 0x3FFF, dut_error=0.
- K=3, same input, weights 0 -> 14 writes of 0x0000. Then flip input row 5 to 0x0000 -> unchanged 0x0000 (M<=3 per window).
- K=1, weight 0x1, NR=4, NC=8, rows 0xA5, 0x3C, 0xFF, 0x00 -> writes 0xA5, 0x3C, 0xFF, 0x00. Upper bits zero.
- K=5 (KMAX), NR=5, NC=5, checkerboard input matching the weights -> single write 0x0001 at OUT_BASE. K=6 -> dut_error=1, no write strobes, busy low within 10 cycles.
- Random K in 1..5, NR/NC in K..16, random data; results compared against a reference model -> all words match, exact write count OR.
- reset_b low mid-CONV on row 2 -> all outputs 0 at once. A following dut_valid job completes correctly; dut_valid pulses while busy are ignored.
